// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - shared ALU operation encodings
// Contents: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT (3-bit alu_func codes)
package mips_alu_pkg;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/mips_multicycle_ctrl_pkg.sv
// rtl/mips_multicycle_ctrl_pkg.sv - state, opcode, funct and mux-select encodings
// Contents: state_t (13 states), OP_*/FN_* constants, SRCB_*/PCSRC_* selects, ctrl_t output bundle
package mips_multicycle_ctrl_pkg;
  localparam int CTRL_STATE_W = 4;

  typedef enum logic [CTRL_STATE_W-1:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_R_WB     = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WB   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_IMM_EXEC = 4'd9,
    ST_IMM_WB   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_ILLEGAL  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_func;
    logic       illegal_instr;
    logic       instr_done;
  } ctrl_t;
endpackage

// File: rtl/mips_alu_decode.sv
// rtl/mips_alu_decode.sv - R-type funct to ALU operation mapping (combinational)
// Ports: funct (in, 6) instr[5:0]; alu_func (out, 3) ALU operation;
//        funct_illegal (out, 1) funct is not a supported R-type operation
module mips_alu_decode
  import mips_multicycle_ctrl_pkg::*;
  import mips_alu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_func,
  output logic       funct_illegal
);

  always_comb begin
    alu_func      = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADD, FN_ADDU: alu_func = ALU_ADD;
      FN_SUB, FN_SUBU: alu_func = ALU_SUB;
      FN_AND:          alu_func = ALU_AND;
      FN_OR:           alu_func = ALU_OR;
      FN_SLT:          alu_func = ALU_SLT;
      default:         funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS32 control FSM
// Ports: clk, rst_n (async active-low); opcode/funct from IR; alu_zero; mem_ready handshake;
//        datapath controls pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
//        mem_to_reg, alu_src_a, alu_src_b[1:0], pc_src[1:0], alu_func[2:0];
//        status illegal_instr (sticky), instr_done (last-cycle pulse), state (debug)
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
  import mips_alu_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_func,
  output logic               illegal_instr,
  output logic               instr_done,
  output logic [STATE_W-1:0] state
);

  state_t     state_q, state_d;
  ctrl_t      ctrl;
  logic [2:0] dec_alu_func;
  logic       dec_funct_illegal;

  mips_alu_decode u_alu_decode (
    .funct         (funct),
    .alu_func      (dec_alu_func),
    .funct_illegal (dec_funct_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:        state_d = ST_EXEC_R;
          OP_LW, OP_SW:    state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:  state_d = ST_BRANCH;
          OP_ADDI, OP_ADDIU: state_d = ST_IMM_EXEC;
          OP_J:            state_d = ST_JUMP;
          default:         state_d = ST_ILLEGAL;
        endcase
      end
      ST_EXEC_R:   state_d = dec_funct_illegal ? ST_ILLEGAL : ST_R_WB;
      ST_MEM_ADDR: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
      ST_IMM_EXEC: state_d = ST_IMM_WB;
      ST_R_WB, ST_MEM_WB, ST_BRANCH, ST_IMM_WB, ST_JUMP: state_d = ST_FETCH;
      // ILLEGAL is terminal; unused encodings fall into it as well
      default:     state_d = ST_ILLEGAL;
    endcase
  end

  always_comb begin
    ctrl          = '0;
    ctrl.alu_func = ALU_ADD;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.pc_write  = mem_ready;
        ctrl.ir_write  = mem_ready;
      end
      ST_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;  // branch target into ALUOut
      ST_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_func  = dec_alu_func;
      end
      ST_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_ADDR, ST_IMM_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_func   = ALU_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.pc_write   = (opcode == OP_BNE) ? !alu_zero : alu_zero;
        ctrl.instr_done = 1'b1;
      end
      ST_IMM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: begin
        ctrl               = '0;
        ctrl.illegal_instr = 1'b1;
      end
    endcase
    // Async reset holds FETCH in the state register, so outputs are forced
    // low here to drop any pending memory request without waiting for an edge.
    if (!rst_n) ctrl = '0;
  end

  assign pc_write      = ctrl.pc_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign i_or_d        = ctrl.i_or_d;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign pc_src        = ctrl.pc_src;
  assign alu_func      = ctrl.alu_func;
  assign illegal_instr = ctrl.illegal_instr;
  assign instr_done    = ctrl.instr_done;
  assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
  import mips_multicycle_ctrl_pkg::*;
  import mips_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, illegal_instr, instr_done;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_func;
  logic [3:0] state;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_func(alu_func),
    .illegal_instr(illegal_instr), .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  wire [17:0] obs_o = {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write,
                       reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_func,
                       illegal_instr, instr_done};
  wire [21:0] obs = {state, obs_o};

  typedef struct {
    logic [3:0]  st;
    bit          mr;
    bit          az;
    logic [17:0] o;
  } cyc_t;

  cyc_t exp_q[$];
  int   lat_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_cnt = 0;
  logic [5:0] fn_tab [7] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A};
  logic [5:0] op_tab [8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09, 6'h02};

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [17:0] pk(input bit pcw, irw, mrd, mwr, iod, rw, rd, m2r, asa,
                                     input logic [1:0] asb, psrc, input logic [2:0] af,
                                     input bit ill, done);
    return {pcw, irw, mrd, mwr, iod, rw, rd, m2r, asa, asb, psrc, af, ill, done};
  endfunction

  // Expected ALU op for an R-type funct; bit 3 flags an unsupported funct.
  function automatic logic [3:0] ref_alu(input logic [5:0] fn);
    case (fn)
      6'h20, 6'h21: return {1'b0, ALU_ADD};
      6'h22, 6'h23: return {1'b0, ALU_SUB};
      6'h24:        return {1'b0, ALU_AND};
      6'h25:        return {1'b0, ALU_OR};
      6'h2A:        return {1'b0, ALU_SLT};
      default:      return {1'b1, ALU_ADD};
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input bit mr, input bit az, input logic [17:0] o);
    cyc_t c;
    c.st = st; c.mr = mr; c.az = az; c.o = o;
    exp_q.push_back(c);
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Expected cycle-by-cycle trace of one instruction, built phase by phase.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit az,
                       input int fw, input int mw);
    logic [3:0] ra;
    ra = ref_alu(fn);
    for (int i = 0; i < fw; i++)
      push(ST_FETCH, 0, rb(), pk(0,0,1,0,0,0,0,0,0, 2'd1, 2'd0, ALU_ADD, 0,0));
    push(ST_FETCH, 1, rb(), pk(1,1,1,0,0,0,0,0,0, 2'd1, 2'd0, ALU_ADD, 0,0));
    push(ST_DECODE, rb(), rb(), pk(0,0,0,0,0,0,0,0,0, 2'd3, 2'd0, ALU_ADD, 0,0));
    case (op)
      6'h00: begin
        push(ST_EXEC_R, rb(), rb(), pk(0,0,0,0,0,0,0,0,1, 2'd0, 2'd0, ra[2:0], 0,0));
        if (!ra[3]) begin
          push(ST_R_WB, rb(), rb(), pk(0,0,0,0,0,1,1,0,0, 2'd0, 2'd0, ALU_ADD, 0,1));
          lat_q.push_back(4 + fw);
        end
      end
      6'h23: begin
        push(ST_MEM_ADDR, rb(), rb(), pk(0,0,0,0,0,0,0,0,1, 2'd2, 2'd0, ALU_ADD, 0,0));
        for (int i = 0; i <= mw; i++)
          push(ST_MEM_RD, i == mw, rb(), pk(0,0,1,0,1,0,0,0,0, 2'd0, 2'd0, ALU_ADD, 0,0));
        push(ST_MEM_WB, rb(), rb(), pk(0,0,0,0,0,1,0,1,0, 2'd0, 2'd0, ALU_ADD, 0,1));
        lat_q.push_back(5 + fw + mw);
      end
      6'h2B: begin
        push(ST_MEM_ADDR, rb(), rb(), pk(0,0,0,0,0,0,0,0,1, 2'd2, 2'd0, ALU_ADD, 0,0));
        for (int i = 0; i <= mw; i++)
          push(ST_MEM_WR, i == mw, rb(), pk(0,0,0,1,1,0,0,0,0, 2'd0, 2'd0, ALU_ADD, 0, i == mw));
        lat_q.push_back(4 + fw + mw);
      end
      6'h04, 6'h05: begin
        push(ST_BRANCH, rb(), az, pk((op == 6'h04) ? az : !az, 0,0,0,0,0,0,0,1,
                                     2'd0, 2'd1, ALU_SUB, 0,1));
        lat_q.push_back(3 + fw);
      end
      6'h08, 6'h09: begin
        push(ST_IMM_EXEC, rb(), rb(), pk(0,0,0,0,0,0,0,0,1, 2'd2, 2'd0, ALU_ADD, 0,0));
        push(ST_IMM_WB, rb(), rb(), pk(0,0,0,0,0,1,0,0,0, 2'd0, 2'd0, ALU_ADD, 0,1));
        lat_q.push_back(4 + fw);
      end
      6'h02: begin
        push(ST_JUMP, rb(), rb(), pk(1,0,0,0,0,0,0,0,0, 2'd0, 2'd2, ALU_ADD, 0,1));
        lat_q.push_back(3 + fw);
      end
      default: ;
    endcase
  endtask

  task automatic add_illegal(input int n);
    for (int i = 0; i < n; i++)
      push(ST_ILLEGAL, rb(), rb(), pk(0,0,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'd0, 1,0));
  endtask

  // Called at posedge+1: drives one expected cycle, checks at the falling edge.
  task automatic run(input int n);
    cyc_t c;
    for (int k = 0; k < n && exp_q.size() > 0; k++) begin
      c = exp_q.pop_front();
      mem_ready = c.mr;
      alu_zero  = c.az;
      @(negedge clk);
      check("cycle", 32'(obs), 32'({c.st, c.o}));
      cyc_cnt++;
      if (instr_done === 1'b1) begin
        if (lat_q.size() == 0) check("latency_unexpected_done", 32'(cyc_cnt), 32'(0));
        else                   check("latency", 32'(cyc_cnt), 32'(lat_q.pop_front()));
        cyc_cnt = 0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_all();
    run(exp_q.size());
    check("latency_pending", 32'(lat_q.size()), 32'(0));
  endtask

  // Called at posedge+1, i.e. between clock edges.
  task automatic do_reset(input int n);
    mem_ready = 1'b1;
    alu_zero  = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("reset_immediate", 32'(obs), 32'({ST_FETCH, 18'h0}));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("reset_hold", 32'(obs), 32'({ST_FETCH, 18'h0}));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc_cnt = 0;
    exp_q.delete();
    lat_q.delete();
  endtask

  initial begin
    logic [5:0] op, fn;
    // Reset held low for 3 cycles from time 0, then R-type add.
    mem_ready = 1'b1;
    alu_zero  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_init", 32'(obs), 32'({ST_FETCH, 18'h0}));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    opcode = 6'h00; funct = 6'h20;
    build(6'h00, 6'h20, 0, 0, 0);
    run_all();

    // lw with 2 fetch stalls and 3 memory stalls: 10 cycles.
    opcode = 6'h23; funct = 6'($urandom);
    build(6'h23, funct, 0, 2, 3);
    run_all();

    // Branch resolution, both polarities.
    for (int i = 0; i < 4; i++) begin
      opcode = (i < 2) ? 6'h04 : 6'h05;
      funct  = 6'($urandom);
      build(opcode, funct, i[0], 0, 0);
      run_all();
    end

    // sw without and with stalls, then j.
    opcode = 6'h2B; build(6'h2B, funct, 0, 0, 0); run_all();
    opcode = 6'h2B; build(6'h2B, funct, 0, 1, 2); run_all();
    opcode = 6'h02; build(6'h02, funct, 0, 0, 0); run_all();

    // Random legal instruction stream.
    for (int i = 0; i < 40; i++) begin
      opcode = op_tab[$urandom_range(0, 7)];
      funct  = (opcode == 6'h00) ? fn_tab[$urandom_range(0, 6)] : 6'($urandom);
      build(opcode, funct, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
      run_all();
    end

    // Illegal opcode 0x3F: sticky for 20 cycles, cleared by reset.
    opcode = 6'h3F;
    build(6'h3F, 6'h20, 0, 1, 0);
    add_illegal(20);
    run_all();
    do_reset(2);

    // Random unsupported opcode.
    do begin
      op = 6'($urandom);
    end while (op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h23, 6'h2B});
    opcode = op;
    build(op, 6'h20, 0, 0, 0);
    add_illegal(3);
    run_all();
    do_reset(1);

    // R-type with funct 0x00 goes illegal after EXEC_R.
    opcode = 6'h00; funct = 6'h00;
    build(6'h00, 6'h00, 0, 0, 0);
    add_illegal(5);
    run_all();
    do_reset(1);

    // Async reset in the middle of a MEM_RD wait.
    opcode = 6'h23; funct = 6'h00;
    build(6'h23, 6'h00, 0, 0, 3);
    run(4);
    mem_ready = 1'b0;
    #1;
    check("mid_rd_request", 32'({state, mem_read, i_or_d}), 32'({ST_MEM_RD, 2'b11}));
    do_reset(2);

    // Clean fetch after release.
    for (int i = 0; i < 3; i++) begin
      fn = fn_tab[$urandom_range(0, 6)];
      opcode = 6'h00; funct = fn;
      build(6'h00, fn, 0, i, 0);
      run_all();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle control FSM for the MIPS32 SOC datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives the ALU function select and operand muxes, and consumes the ALU isZero flag to resolve branches.
- Sits directly upstream of the ALU. One instruction is in flight at a time. Memory accesses use a ready handshake.

Parameters:
- STATE_W, 4, width of the state register and of the state debug port.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instr[31:26] from the datapath IR; stable from DECODE onward
- funct  in  6  instr[5:0] from the IR
- alu_zero  in  1  ALU isZero output
- mem_ready  in  1  memory handshake; access completes in the cycle it is 1
- pc_write  out  1  load PC
- ir_write  out  1  load IR
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- reg_write  out  1  register file write enable
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  ALU operand a select: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU operand b select: 0 = register B, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm<<2
- pc_src  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target
- alu_func  out  3  ALU operation, using the ALU_ADD/SUB/AND/OR/SLT encodings from the shared ALU defines
- illegal_instr  out  1  sticky; cleared only by reset
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- state  out  STATE_W  current state, for debug

Behaviour:
- Output style: Moore-style decode of the state register. mem_ready gates the FETCH and memory-state outputs; alu_zero gates pc_write in BRANCH.
- While rst_n is 0: state = FETCH and every output is 0, including illegal_instr.
- First fetch request: in the first cycle with rst_n = 1.
- Any output not listed for a state is 0. alu_func defaults to ALU_ADD.
- FETCH:
  - Outputs: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 1, pc_src = 0.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 3 (branch target into ALUOut).
  - Dispatch on opcode:
    - 0x00 -> EXEC_R
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x04 or 0x05 -> BRANCH
    - 0x08 or 0x09 -> IMM_EXEC
    - 0x02 -> JUMP
    - any other opcode -> ILLEGAL
- EXEC_R:
  - Outputs: alu_src_a = 1, alu_src_b = 0.
  - funct to alu_func:
    - 0x20 or 0x21 -> ADD
    - 0x22 or 0x23 -> SUB
    - 0x24 -> AND
    - 0x25 -> OR
    - 0x2A -> SLT
  - Any other funct -> ILLEGAL; otherwise -> R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0, instr_done = 1; -> FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, ADD; -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read = 1, i_or_d = 1; stays until mem_ready, then -> MEM_WB.
- MEM_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 1, instr_done = 1; -> FETCH.
- MEM_WR: mem_write = 1, i_or_d = 1; instr_done = mem_ready; stays until mem_ready, then -> FETCH.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 0, SUB, pc_src = 1.
  - pc_write = alu_zero for beq (0x04), !alu_zero for bne (0x05).
  - instr_done = 1; -> FETCH.
- IMM_EXEC: alu_src_a = 1, alu_src_b = 2, ADD; -> IMM_WB.
- IMM_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, instr_done = 1; -> FETCH.
- JUMP: pc_src = 2, pc_write = 1, instr_done = 1; -> FETCH.
- ILLEGAL: all outputs 0 except illegal_instr = 1. Terminal state; left only by reset.
- Memory requests are held constant while waiting for mem_ready; no timeout.
- Reset asserted mid-instruction: the next edge-free instant forces FETCH with outputs 0, and any pending memory request drops immediately.
- Latency in cycles with mem_ready held at 1:
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - addi: 4
  - j: 3
- Each memory wait cycle adds 1 cycle.
- Unused state encodings decode to ILLEGAL behaviour.

Decomposition:
- Shared package/header holds:
  - state encodings (STATE_W = 4, 13 states)
  - opcode and funct constants
  - alu_src_b and pc_src select encodings
- ALU encodings come from the existing ALU defines header; they are not redefined here.
- Sub-module mips_alu_decode: combinational mapping of funct to {alu_func, funct_illegal}. Instantiated once; reusable by a later pipelined decoder.

Test Plan:
- Reset then add: rst_n low 3 cycles, then opcode 0x00, funct 0x20, mem_ready = 1.
  - Required: states FETCH, DECODE, EXEC_R, R_WB.
  - alu_func = ALU_ADD in EXEC_R; reg_write = 1 and reg_dst = 1 in R_WB.
  - instr_done pulses once; all outputs 0 during reset.
- lw with stalls: opcode 0x23, mem_ready = 0 for 2 cycles in FETCH and 3 cycles in MEM_RD.
  - Required: total 10 cycles.
  - mem_read held through both waits; i_or_d = 1 only in MEM_RD.
  - mem_to_reg = 1 in MEM_WB.
- Branch resolution:
  - beq with alu_zero = 1 -> pc_write = 1, pc_src = 1.
  - beq with alu_zero = 0 -> pc_write = 0.
  - bne inverts both cases.
  - Each takes 3 cycles.
- sw and j:
  - sw: mem_write = 1 for exactly the MEM_WR cycle(s); reg_write never 1.
  - j: pc_write = 1 with pc_src = 2 in its third cycle.
- Illegal decode:
  - opcode 0x3F -> ILLEGAL after DECODE; illegal_instr stays 1 for 20 cycles.
  - R-type with funct 0x00 -> ILLEGAL after EXEC_R.
  - Reset clears both.
- Async reset mid-MEM_RD: drop rst_n between clock edges.
  - Required: mem_read falls without waiting for a clock edge; state = FETCH.
  - Clean fetch resumes after release.
